// File: rtl/square_seq.sv
// ----------------------------------------------------------------------------
// square_seq
//
// Sequential shift-add squarer for the calculator datapath. It computes
// result = operand * operand and uses the same init/done level handshake
// as the square-root unit, so the calculator top can square a root and
// compare it with the original value.
//
// The datapath has three registers:
//   A : 2*WIDTH multiplicand. It starts as the zero-extended operand and
//       shifts left once per multiplier bit.
//   B : WIDTH multiplier shift register. It starts as the operand and
//       shifts right once per bit.
//   P : 2*WIDTH partial-product accumulator.
// The loop stops as soon as B becomes zero. Short operands therefore
// finish early: latency = 2 + 3*bitlen(operand) + popcount(operand).
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous, active-high reset
//   init    : start request (level), sampled only while idle
//   operand : unsigned value to square, captured on the init edge
//   result  : registered square, updated only on entry to FINAL
//   done    : high while in FINAL
//   busy    : high while computing (every state except INICIO and FINAL)
// ----------------------------------------------------------------------------
module square_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [2:0] {
        INICIO      = 3'd0,
        VERIFICAR_Z = 3'd1,
        VERIFICAR   = 3'd2,
        SUMAR       = 3'd3,
        DESPLAZAR   = 3'd4,
        FINAL       = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 z;

    // The loop ends when no multiplier bits remain.
    assign z = (b_q == '0);

    always_comb begin
        // NOTE: every signal assigned here gets a default first. A path that
        // leaves a signal unassigned would otherwise infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        result_d = result_q;

        case (state_q)
            INICIO: begin
                if (init) begin
                    a_d     = {{WIDTH{1'b0}}, operand};
                    b_d     = operand;
                    p_d     = '0;
                    state_d = VERIFICAR_Z;
                end
            end
            VERIFICAR_Z: begin
                if (z) begin
                    // result is written only here, so a reset or an abort
                    // never exposes a partial product.
                    result_d = p_q;
                    state_d  = FINAL;
                end else begin
                    state_d  = VERIFICAR;
                end
            end
            VERIFICAR: begin
                state_d = b_q[0] ? SUMAR : DESPLAZAR;
            end
            SUMAR: begin
                // A never exceeds operand << (WIDTH-1), so the sum fits in
                // 2*WIDTH bits.
                p_d     = p_q + a_q;
                state_d = DESPLAZAR;
            end
            DESPLAZAR: begin
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                state_d = VERIFICAR_Z;
            end
            FINAL: begin
                // Holding init high must not retrigger a computation.
                if (!init) begin
                    state_d = INICIO;
                end
            end
            default: begin
                state_d = INICIO;
            end
        endcase

        // done and busy are decoded from the next state and then registered.
        // This keeps them aligned with state_q and avoids any combinational
        // path from the inputs to the outputs.
        done_d = (state_d == FINAL);
        busy_d = (state_d != INICIO) && (state_d != FINAL);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. All flops then
        // update together on the edge, and no flop sees another flop's new
        // value within the same cycle.
        if (rst) begin
            state_q  <= INICIO;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_square_seq.sv
// ----------------------------------------------------------------------------
// tb_square_seq
//
// Directed and random bench for square_seq (WIDTH=16). Each start pushes its
// expected square and expected latency onto a scoreboard queue. The entry is
// popped and compared when done rises. Inputs are driven on the falling edge,
// and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_square_seq;

    localparam int WIDTH = 16;
    localparam int TIMEOUT_EDGES = 200;

    typedef struct {
        logic [2*WIDTH-1:0] res;
        int                 lat;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 init;
    logic [WIDTH-1:0]     operand;
    logic [2*WIDTH-1:0]   result;
    logic                 done;
    logic                 busy;

    int   checks;
    int   errors;
    exp_t sb[$];

    square_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .init    (init),
        .operand (operand),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Latency model: 2 + 3*bit length + popcount.
    function automatic int model_lat(input logic [WIDTH-1:0] op);
        int l;
        int pc;
        l  = 0;
        pc = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (op[i]) begin
                l = i + 1;
                pc++;
            end
        end
        return 2 + 3 * l + pc;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge while the DUT is in INICIO. It raises init
    // with op and waits (bounded) for done. If change_op is set, the operand
    // is changed right after the init edge.
    task automatic run_op(input logic [WIDTH-1:0] op, input logic change_op,
                          input logic [WIDTH-1:0] new_op);
        exp_t e;
        exp_t got;
        int   edges;
        logic busy_ok;
        e.res = (2*WIDTH)'(op) * (2*WIDTH)'(op);
        e.lat = model_lat(op);
        sb.push_back(e);
        operand = op;
        init    = 1'b1;
        edges   = 0;
        busy_ok = 1'b1;
        do begin
            tick();
            edges++;
            if (change_op && edges == 1) operand = new_op;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && edges < TIMEOUT_EDGES);
        got = sb.pop_front();
        check("done_seen", 64'(done), 64'(1));
        check("latency", 64'(edges), 64'(got.lat));
        check("result", 64'(result), 64'(got.res));
        check("busy_during_calc", 64'(busy_ok), 64'(1));
        check("busy_in_final", 64'(busy), 64'(0));
    endtask

    // Keeps init high in FINAL. The DUT must stay there with result unchanged.
    task automatic hold_final(input int n);
        logic [2*WIDTH-1:0] saved;
        saved = result;
        repeat (n) begin
            tick();
            check("hold_done", 64'(done), 64'(1));
            check("hold_busy", 64'(busy), 64'(0));
            check("hold_result", 64'(result), 64'(saved));
        end
    endtask

    // Drops init for one cycle. done must fall, and result must persist.
    task automatic release_init();
        logic [2*WIDTH-1:0] saved;
        saved = result;
        init  = 1'b0;
        tick();
        check("release_done", 64'(done), 64'(0));
        check("release_busy", 64'(busy), 64'(0));
        check("release_result", 64'(result), 64'(saved));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        init    = 1'b0;
        operand = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("reset_result", 64'(result), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));

        // Zero operand: done two edges after the init edge, then held.
        run_op(16'd0, 1'b0, 16'd0);
        hold_final(3);
        release_init();

        // Bit-length and popcount latency.
        run_op(16'd12, 1'b0, 16'd0);
        release_init();
        run_op(16'd1, 1'b0, 16'd0);
        release_init();

        // Worst case: 66 edges, result 0xFFFE0001.
        run_op(16'hFFFF, 1'b0, 16'd0);
        check("worst_result_const", 64'(result), 64'h0000_0000_FFFE_0001);
        release_init();

        // An operand change after the init edge is ignored.
        run_op(16'h00FF, 1'b1, 16'h1234);
        check("stability_const", 64'(result), 64'h0000_0000_0000_FE01);
        release_init();

        // Reset mid-operation at edge 20.
        operand = 16'hFFFF;
        init    = 1'b1;
        repeat (19) tick();
        check("midop_busy_before_rst", 64'(busy), 64'(1));
        rst  = 1'b1;
        init = 1'b0;
        tick();
        rst = 1'b0;
        check("midop_result", 64'(result), 64'(0));
        check("midop_done", 64'(done), 64'(0));
        check("midop_busy", 64'(busy), 64'(0));
        tick();
        check("midop_idle_busy", 64'(busy), 64'(0));
        check("midop_idle_done", 64'(done), 64'(0));
        run_op(16'd3, 1'b0, 16'd0);
        check("after_rst_const", 64'(result), 64'(9));
        release_init();

        // Back-to-back random runs with the init re-handshake.
        for (int k = 0; k < 100; k++) begin
            run_op(WIDTH'($urandom_range(0, 65535)), 1'b0, 16'd0);
            hold_final(1);
            release_init();
        end

        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_seq.md
Name: square_seq

Overview:
- Sequential shift-add squarer for the calculator datapath; the inverse operation of the square-root unit.
- Computes result = operand² with the same init/done level handshake the calculator top uses for the square-root unit. The top can square a number and feed it back for checking.
- Contains its own FSM and datapath: multiplicand register, multiplier shift register and partial-product accumulator.
- Terminates early once the remaining multiplier bits are zero.

Parameters:
- WIDTH, 16, operand width in bits; result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- init  input  1  start request, level; sampled only in INICIO.
- operand  input  WIDTH  unsigned value to square; captured on the init edge.
- result  output  2*WIDTH  registered square; updated only on entry to FINAL.
- done  output  1  high while in FINAL.
- busy  output  1  high in every state except INICIO and FINAL.

Behaviour:
- Reset (rst=1 at a rising edge, any state):
  - state <= INICIO; result <= 0; accumulator, multiplicand and multiplier <= 0.
  - done=0, busy=0 next cycle.
  - Reset mid-operation aborts with no partial result visible.
- Internal registers:
  - A: 2*WIDTH multiplicand.
  - B: WIDTH multiplier shift register.
  - P: 2*WIDTH accumulator.
  - z = (B==0), combinational.
- FSM states: INICIO, VERIFICAR_Z, VERIFICAR, SUMAR, DESPLAZAR, FINAL.
  - INICIO:
    - init=1: A <= zero-extended operand, B <= operand, P <= 0, go VERIFICAR_Z.
    - init=0: stay.
  - VERIFICAR_Z: z ? FINAL : VERIFICAR. On the transition to FINAL, result <= P.
  - VERIFICAR: B[0] ? SUMAR : DESPLAZAR.
  - SUMAR: P <= P + A (2*WIDTH wide, no overflow possible), go DESPLAZAR.
  - DESPLAZAR: A <= A << 1, B <= B >> 1 (logical), go VERIFICAR_Z.
  - FINAL:
    - done=1; result held.
    - init=1: stay. init=0: go INICIO.
  - Illegal or unused state encodings go to INICIO.
- Handshake:
  - A held-high init produces exactly one computation.
  - The requester must drop init after done before the next start.
  - operand changes after the init edge are ignored.
  - init pulses while busy are ignored.
- Latency: from the rising edge that samples init=1 in INICIO to the first cycle with done=1 is 2 + 3*L + popcount(operand) clock edges.
  - L = bit length of operand (index of MSB set + 1; 0 for operand=0).
  - WIDTH=16 maximum is 66 cycles (operand=0xFFFF).
- Outputs are registered state decodes; no combinational path from inputs to outputs.
- result stays valid after leaving FINAL until the next completion or reset.

Test Plan:
- Zero operand: rst, then operand=0, init=1 held.
  - Expect done=1 two edges after the init edge, result=0x00000000.
  - State stays FINAL while init=1; done=0 one cycle after init drops.
- Bit-length and popcount latency:
  - operand=12 (0b1100): result=144 (0x00000090), done after 2+12+2=16 edges.
  - operand=1: result=1, done after 6 edges.
- Worst case: operand=0xFFFF.
  - Expect result=0xFFFE0001, done after exactly 66 edges.
  - busy=1 throughout the computation, busy=0 in FINAL.
- Operand stability: start with operand=0x00FF, change operand to 0x1234 on the next cycle.
  - Expect result=0x0000FE01.
- Reset mid-operation: start operand=0xFFFF, assert rst for 1 cycle at edge 20.
  - Expect state INICIO, result=0, done=0, busy=0.
  - A following start with operand=3 gives result=9.
- Back-to-back with init re-handshake: 100 random operands, each init held until done, dropped one cycle, then reasserted.
  - Expect result=operand² for every run.
  - Latency matches the formula each time; no extra computation while init is held in FINAL.
